// File: rtl/id_issue_buffer.sv
// id_issue_buffer: in-order decode-to-issue FIFO that also remembers the last consumed entry.
// Define ID_ISSUE_BUF_PREV_EN to build the last-consumed (prev) register; otherwise prev outputs are tied to zero.
package config_pkg;
    typedef struct packed {
        logic reserved;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module id_issue_buffer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type scoreboard_entry_t = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  scoreboard_entry_t          decoded_instr_i,
    input  logic [31:0]                orig_instr_i,
    input  logic                       is_ctrl_flow_i,
    input  logic                       decoded_instr_valid_i,
    output logic                       decoded_instr_ready_o,
    output scoreboard_entry_t          issue_instr_o,
    output logic [31:0]                orig_instr_o,
    output logic                       is_ctrl_flow_o,
    output logic                       issue_instr_valid_o,
    input  logic                       issue_instr_ack_i,
    output scoreboard_entry_t          issue_instr_prev_o,
    output logic                       prev_valid_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        scoreboard_entry_t instr;
        logic [31:0]       orig;
        logic              ctrl;
    } slot_t;

    slot_t          mem_q [DEPTH];
    logic [PW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           push, pop;
    logic           unused_cfg;

    assign unused_cfg = ^CVA6Cfg;

    // Ready is derived from the registered count only, keeping ack off the ready path.
    assign decoded_instr_ready_o = (cnt_q != CW'(DEPTH)) && !rst_i && !flush_i;
    assign issue_instr_valid_o   = cnt_q != '0;
    assign push                  = decoded_instr_valid_i && decoded_instr_ready_o;
    assign pop                   = issue_instr_valid_o && issue_instr_ack_i;
    assign occupancy_o           = cnt_q;

    assign issue_instr_o  = mem_q[rptr_q].instr;
    assign orig_instr_o   = mem_q[rptr_q].orig;
    assign is_ctrl_flow_o = mem_q[rptr_q].ctrl;

    always_comb begin
        rptr_d = flush_i ? '0 : rptr_q + PW'(pop);
        wptr_d = flush_i ? '0 : wptr_q + PW'(push);
        cnt_d  = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wptr_q] <= '{instr: decoded_instr_i, orig: orig_instr_i, ctrl: is_ctrl_flow_i};
    end

`ifdef ID_ISSUE_BUF_PREV_EN
    scoreboard_entry_t prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;

    // A pop during flush still captures the entry, but it is marked invalid.
    always_comb begin
        prev_d       = pop ? issue_instr_o : prev_q;
        prev_valid_d = flush_i ? 1'b0 : (pop || prev_valid_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign issue_instr_prev_o = prev_q;
    assign prev_valid_o       = prev_valid_q;
`else
    assign issue_instr_prev_o = '0;
    assign prev_valid_o       = 1'b0;
`endif
endmodule

// File: tb/tb_id_issue_buffer.sv
// tb_id_issue_buffer: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_id_issue_buffer;
    localparam int DEPTH = 2;
    typedef logic [15:0] entry_t;
    typedef struct {
        entry_t      i;
        logic [31:0] o;
        logic        c;
    } ent_t;

    logic        clk = 0;
    logic        rst = 1, flush = 0, vin = 0, ack = 0, ctrl_in = 0;
    entry_t      din = '0;
    logic [31:0] oin = '0;
    logic        ready, vout, ctrl_out, pv;
    entry_t      dout, prev;
    logic [31:0] oout;
    logic [$clog2(DEPTH):0] occ;

    int checks = 0, passed = 0;
    ent_t   q[$];
    entry_t m_prev = '0;
    logic   m_pv = 0;

    id_issue_buffer #(.scoreboard_entry_t(entry_t), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .decoded_instr_i(din), .orig_instr_i(oin), .is_ctrl_flow_i(ctrl_in),
        .decoded_instr_valid_i(vin), .decoded_instr_ready_o(ready),
        .issue_instr_o(dout), .orig_instr_o(oout), .is_ctrl_flow_o(ctrl_out),
        .issue_instr_valid_o(vout), .issue_instr_ack_i(ack),
        .issue_instr_prev_o(prev), .prev_valid_o(pv), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares DUT against the model, then advances the model across the coming edge.
    always @(negedge clk) begin
        int   n;
        logic m_ready, do_pop, do_push;
        ent_t e;
        n = q.size();
        m_ready = (n != DEPTH) && !rst && !flush;
        chk("valid", 64'(vout), 64'(n != 0));
        chk("ready", 64'(ready), 64'(m_ready));
        chk("occupancy", 64'(occ), 64'(n));
        if (n != 0) begin
            chk("head_instr", 64'(dout), 64'(q[0].i));
            chk("head_orig", 64'(oout), 64'(q[0].o));
            chk("head_ctrl", 64'(ctrl_out), 64'(q[0].c));
        end
        chk("prev", 64'(prev), 64'(m_prev));
        chk("prev_valid", 64'(pv), 64'(m_pv));
        if (rst) begin
            q.delete();
            m_prev = '0;
            m_pv = 0;
        end else begin
            do_pop = (n != 0) && ack;
            do_push = vin && m_ready;
            if (do_pop) begin
                e = q.pop_front();
`ifdef ID_ISSUE_BUF_PREV_EN
                m_prev = e.i;
                m_pv = 1;
`endif
            end
            if (do_push) q.push_back('{din, oin, ctrl_in});
            if (flush) begin
                q.delete();
                m_pv = 0;
            end
        end
    end

    task automatic cyc(input logic v, input logic a, input logic f, input logic r);
        vin = v; ack = a; flush = f; rst = r;
        if (v) begin
            din = entry_t'($urandom);
            oin = $urandom;
            ctrl_in = 1'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    // Same as cyc but keeps the currently offered entry (decode holding it).
    task automatic hold(input logic a);
        ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);            // push A, ack low
        repeat (2) cyc(0, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0); // drain
        cyc(1, 0, 0, 0);            // A
        cyc(1, 0, 0, 0);            // B -> full
        cyc(1, 0, 0, 0);            // C offered, refused
        hold(0);
        hold(1);                    // pop A, C still refused
        hold(0);                    // C accepted
        vin = 0;
        repeat (4) cyc(0, 1, 0, 0);
        repeat (6) cyc(1, 1, 0, 0); // streaming
        repeat (3) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);            // flush with push of E
        repeat (2) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 1);            // reset while full, ack high
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 3000; k++)
            cyc(1'($urandom), 1'($urandom), $urandom_range(31) == 0, $urandom_range(63) == 0);
        repeat (4) cyc(0, 1, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/id_issue_buffer.md
# id_issue_buffer

Decoupling FIFO between the decode stage and the issue stage. It accepts decoded scoreboard entries from decode with a valid/ready handshake and presents them in order to the issue stage's `decoded_instr_i`/`decoded_instr_valid_i`/`decoded_instr_ack_o` handshake. It also keeps the most recently issued entry, which drives the issue stage's `decoded_instr_i_prev` input for FMOV conditional-move handling. Flushing unissued instructions empties it.

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; only used for typing.
- `scoreboard_entry_t`, `logic`: decoded instruction entry type.
- `DEPTH`, 2: number of FIFO entries; must be a power of two and at least 2.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: drop all buffered entries (flush_unissued_instr).
- `decoded_instr_i` in `scoreboard_entry_t`: entry from decode.
- `orig_instr_i` in 32: raw instruction bits.
- `is_ctrl_flow_i` in 1: entry is a control-flow instruction.
- `decoded_instr_valid_i` in 1: decode offers an entry.
- `decoded_instr_ready_o` out 1: buffer can accept an entry.
- `issue_instr_o` out `scoreboard_entry_t`: head entry.
- `orig_instr_o` out 32: head raw bits.
- `is_ctrl_flow_o` out 1: head control-flow flag.
- `issue_instr_valid_o` out 1: head is valid.
- `issue_instr_ack_i` in 1: issue stage consumes the head.
- `issue_instr_prev_o` out `scoreboard_entry_t`: last consumed entry.
- `prev_valid_o` out 1: `issue_instr_prev_o` holds a real entry.
- `occupancy_o` out `$clog2(DEPTH)+1`: number of buffered entries.

## Operation
- Storage: `DEPTH` slots, read pointer `rptr`, write pointer `wptr` and counter `cnt`.
  - Both pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` without special casing.
- Push: happens when `decoded_instr_valid_i && decoded_instr_ready_o`.
  - Writes `{decoded_instr_i, orig_instr_i, is_ctrl_flow_i}` to slot `wptr`.
  - Then `wptr++`.
- Pop: happens when `issue_instr_valid_o && issue_instr_ack_i`.
  - Then `rptr++`.
  - The popped entry is copied into the prev register and `prev_valid` is set to 1.
- Counter update:
  - `cnt += push - pop`.
  - Push and pop in the same cycle leave `cnt` unchanged.
- Readiness:
  - `decoded_instr_ready_o = (cnt != DEPTH) && !rst_i && !flush_i`.
  - Ready never depends on `issue_instr_ack_i`, so there is no combinational path from ack to ready.
- Output drive:
  - `issue_instr_valid_o = (cnt != 0)`.
  - Head outputs are driven from slot `rptr`.
  - When empty, the head outputs hold stale data, but `issue_instr_valid_o` is 0.
- Full: no push is possible, even if a pop happens that same cycle. The slot frees one cycle later.
- Empty: an ack while `issue_instr_valid_o` is 0 is ignored; no pop occurs.
- Flush:
  - `cnt`, `rptr` and `wptr` go to 0 and `prev_valid` goes to 0.
  - A push offered in the flush cycle is dropped, because ready is low.
  - An ack in the flush cycle still pops.
- Priority order: `rst_i` > `flush_i` > push/pop.
- The storage array is not reset; only the control state is reset.

## Timing
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1. There is no bypass.
- Throughput: one push and one pop per cycle in steady state, when `DEPTH` ≥ 2.
- Reset values:
  - `issue_instr_valid_o` = 0
  - `decoded_instr_ready_o` = 0 during reset, and 1 in the first cycle after reset is released
  - `prev_valid_o` = 0
  - `occupancy_o` = 0
  - `issue_instr_prev_o` = all zeros
  - The head data outputs are undefined while valid is 0.
- Reset or flush in the middle of a burst: it takes effect at the next clock edge. Valid is 0 in the following cycle.
- `issue_instr_prev_o` updates on the edge that ends the pop cycle. It is stable for the whole cycle in which the next head is presented.

## Configuration
- Macro: `ID_ISSUE_BUF_PREV_EN`.
- Defined:
  - The prev register and `prev_valid_o` are implemented as described above.
  - This supports FMOV dependence on the previous instruction.
- Not defined:
  - No prev register is synthesised.
  - `issue_instr_prev_o` is tied to all zeros and `prev_valid_o` is tied to 0.
  - FIFO behaviour is otherwise identical.

## Test plan
- Reset, then push A at cycle 1 with ack held low. Required: valid is 1 at cycle 2 with head = A, and `occupancy_o` = 1.
- With `DEPTH`=2 and no ack, push A, B, C back-to-back. Required:
  - ready goes to 0 after B and C stays held at decode;
  - `occupancy_o` = 2;
  - ack at cycle 4 pops A;
  - ready returns to 1 at cycle 5 and C is then accepted.
- Stream A, B, C, D with valid and ack held at 1. Required:
  - one entry per cycle at the head, in order A, B, C, D;
  - `occupancy_o` stays at 1;
  - `issue_instr_prev_o` lags the head by one entry, e.g. head = C while prev = B.
- With 2 entries buffered, assert `flush_i` together with a push of E. Required:
  - the next cycle shows valid = 0, `occupancy_o` = 0 and `prev_valid_o` = 0;
  - E is never presented.
- Assert `rst_i` for 1 cycle while the buffer is full and ack is high. Required: all reset values hold in the next cycle, and ready = 1 in the cycle after that.
- Build without `ID_ISSUE_BUF_PREV_EN` and stream A, B. Required: `issue_instr_prev_o` = 0 and `prev_valid_o` = 0 throughout, with FIFO output order unchanged.
